fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 12 +
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and memory (slave).
interface fetch_sequencer_if #(
   parameter int unsigned PC_W = 8
);
   logic            mem_req;
   logic [PC_W-1:0] mem_addr;
   logic [15:0]     mem_rdata;
   logic            mem_ack;

   modport master (output mem_req, mem_addr, input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches instruction words over the memory bus, holds the IR,
// and advances the program counter during the single execute cycle.
module fetch_sequencer #(
   parameter int unsigned PC_W = 8,
   parameter int unsigned IR_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          PS,
   input  logic                IL,
   input  logic [PC_W-1:0]     jump_addr,
   fetch_sequencer_if.master   mem,
   output logic                state,
   output logic [3:0]          opcode,
   output logic [3:0]          DR,
   output logic [3:0]          SA,
   output logic [3:0]          SB,
   output logic [PC_W-1:0]     pc,
   output logic [15:0]         retired
);

   localparam int unsigned RET_W = 16;

   typedef enum logic [1:0] {F_REQ, F_WAIT, EXEC} state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [IR_W-1:0]  ir_q, ir_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic             mem_req_q, mem_req_d;
   logic             exec_q, exec_d;
   logic             ack_ok;
   logic [PC_W-1:0]  br_off;

   // An ack only counts while a request is actually on the bus
   assign ack_ok = mem.mem_ack && mem_req_q;
   assign br_off = {{(PC_W-4){ir_q[11]}}, ir_q[11:8]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= F_REQ;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
         mem_req_q <= 1'b0;
         exec_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         mem_req_q <= mem_req_d;
         exec_q    <= exec_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         F_REQ, F_WAIT: begin
            if (ack_ok) begin
               if (IL) begin
                  ir_d    = IR_W'(mem.mem_rdata);
                  state_d = EXEC;
               end else begin
                  state_d = F_REQ;
               end
            end else if (state_q == F_REQ && mem_req_q) begin
               state_d = F_WAIT;
            end
            // F_REQ without a live request (just out of reset) stays put while mem_req rises
         end
         EXEC: begin
            retired_d = retired_q + RET_W'(1);
            state_d   = F_REQ;
            case (PS)
               2'b01:   pc_d = pc_q + PC_W'(1);
               2'b10:   pc_d = pc_q + br_off;
               2'b11:   pc_d = jump_addr;
               default: pc_d = pc_q;
            endcase
         end
         default: state_d = F_REQ;
      endcase
      mem_req_d = (state_d != EXEC);
      exec_d    = (state_d == EXEC);
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = pc_q;
   assign state        = exec_q;
   assign pc           = pc_q;
   assign retired      = retired_q;
   assign opcode       = ir_q[15:12];
   assign DR           = ir_q[11:8];
   assign SA           = ir_q[7:4];
   assign SB           = ir_q[3:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: linear stimulus with hand-computed expectations.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] PS;
   logic       IL;
   logic [7:0] jump_addr;
   logic       state;
   logic [3:0] opcode, DR, SA, SB;
   logic [7:0] pc;
   logic [15:0] retired;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  cur_pc;
   logic [15:0] exp_ret;

   fetch_sequencer_if #(.PC_W(8)) mif ();

   fetch_sequencer #(.PC_W(8), .IR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .PS(PS), .IL(IL), .jump_addr(jump_addr),
      .mem(mif), .state(state), .opcode(opcode), .DR(DR), .SA(SA), .SB(SB),
      .pc(pc), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in F_REQ with mem_req high; ack arrives after 'delay' cycles (0 = in F_REQ)
   task automatic run_instr(input logic [15:0] data, input logic [1:0] ps, input logic [7:0] ja,
                            input int delay, input logic stray, input logic [7:0] exp_pc);
      for (int i = 0; i < delay; i++) begin
         mif.mem_ack = 1'b0;
         PS = 2'b11; jump_addr = 8'h77;
         tick();
         chk("wait_req", 32'(mif.mem_req), 32'd1);
         chk("wait_addr", 32'(mif.mem_addr), 32'(cur_pc));
         chk("wait_pc", 32'(pc), 32'(cur_pc));
      end
      mif.mem_ack = 1'b1; mif.mem_rdata = data; IL = 1'b1;
      PS = ps; jump_addr = ja;
      tick();
      mif.mem_ack = stray; mif.mem_rdata = 16'hDEAD;
      chk("exec_state", 32'(state), 32'd1);
      chk("exec_req", 32'(mif.mem_req), 32'd0);
      chk("exec_ir", {16'h0, opcode, DR, SA, SB}, 32'(data));
      tick();
      mif.mem_ack = 1'b0;
      exp_ret = exp_ret + 16'd1;
      cur_pc  = exp_pc;
      chk("post_state", 32'(state), 32'd0);
      chk("post_req", 32'(mif.mem_req), 32'd1);
      chk("post_pc", 32'(pc), 32'(exp_pc));
      chk("post_addr", 32'(mif.mem_addr), 32'(exp_pc));
      chk("post_ret", 32'(retired), 32'(exp_ret));
      chk("post_ir", {16'h0, opcode, DR, SA, SB}, 32'(data));
      PS = 2'b11; jump_addr = 8'h77;
   endtask

   initial begin
      rst_n = 1'b0; PS = 2'b00; IL = 1'b1; jump_addr = 8'h00;
      mif.mem_ack = 1'b0; mif.mem_rdata = 16'h0000;
      cur_pc = 8'h00; exp_ret = 16'h0000;
      #12;
      chk("rst_req", 32'(mif.mem_req), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_ret", 32'(retired), 32'd0);
      chk("rst_ir", {16'h0, opcode, DR, SA, SB}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("rel_req", 32'(mif.mem_req), 32'd1);
      chk("rel_addr", 32'(mif.mem_addr), 32'd0);
      chk("rel_state", 32'(state), 32'd0);

      run_instr(16'h1234, 2'b01, 8'h00, 1, 1'b0, 8'h01);
      chk("op1", 32'(opcode), 32'd1);
      chk("dr1", 32'(DR), 32'd2);
      chk("sa1", 32'(SA), 32'd3);
      chk("sb1", 32'(SB), 32'd4);
      run_instr(16'h0000, 2'b11, 8'h05, 0, 1'b0, 8'h05);
      run_instr(16'hAE5C, 2'b10, 8'h00, 1, 1'b0, 8'h03);
      run_instr(16'h0000, 2'b11, 8'hFE, 0, 1'b0, 8'hFE);
      run_instr(16'h5367, 2'b10, 8'h00, 2, 1'b0, 8'h01);
      run_instr(16'h0000, 2'b11, 8'hFF, 0, 1'b0, 8'hFF);
      run_instr(16'h1000, 2'b01, 8'h00, 0, 1'b0, 8'h00);
      run_instr(16'h0000, 2'b11, 8'hA5, 1, 1'b0, 8'hA5);
      run_instr(16'h9ABC, 2'b00, 8'h00, 5, 1'b1, 8'hA5);

      // Ack with IL=0: data dropped, same address re-requested
      tick();
      chk("il0_wait_req", 32'(mif.mem_req), 32'd1);
      mif.mem_ack = 1'b1; mif.mem_rdata = 16'hFFFF; IL = 1'b0;
      tick();
      mif.mem_ack = 1'b0; IL = 1'b1;
      chk("il0_state", 32'(state), 32'd0);
      chk("il0_req", 32'(mif.mem_req), 32'd1);
      chk("il0_addr", 32'(mif.mem_addr), 32'hA5);
      chk("il0_ir", {16'h0, opcode, DR, SA, SB}, 32'h9ABC);
      run_instr(16'h4321, 2'b01, 8'h00, 1, 1'b0, 8'hA6);

      // Preload retired near its wrap point
      force dut.retired_q = 16'hFFFF;
      #1;
      release dut.retired_q;
      exp_ret = 16'hFFFF;
      run_instr(16'h2222, 2'b01, 8'h00, 0, 1'b0, 8'hA7);
      chk("wrap_ret", 32'(retired), 32'h0000);
      run_instr(16'h3333, 2'b01, 8'h00, 1, 1'b0, 8'hA8);

      // Reset in the middle of F_WAIT with a stray ack
      tick();
      chk("mid_req", 32'(mif.mem_req), 32'd1);
      mif.mem_ack = 1'b1; mif.mem_rdata = 16'hF00F;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
      chk("mid_rst_pc", 32'(pc), 32'd0);
      chk("mid_rst_ret", 32'(retired), 32'd0);
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_ir", {16'h0, opcode, DR, SA, SB}, 32'd0);
      tick();
      chk("rst_ack_ir", {16'h0, opcode, DR, SA, SB}, 32'd0);
      chk("rst_ack_req", 32'(mif.mem_req), 32'd0);
      mif.mem_ack = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      cur_pc = 8'h00; exp_ret = 16'h0000;
      chk("rel2_req", 32'(mif.mem_req), 32'd1);
      chk("rel2_addr", 32'(mif.mem_addr), 32'd0);
      run_instr(16'h1234, 2'b01, 8'h00, 1, 1'b0, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
